// File: rtl/cellram_pkg.sv
// Shared types and timing constants for the cellular RAM controller.
//   state_e     : controller FSM states
//   T_ACCESS_NS : RAM async access time (tAA / tWC) in ns
//   CLK_NS      : default system clock period in ns
//   min_cycles  : smallest whole number of clocks covering a time in ns
package cellram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StRecover
  } state_e;

  localparam int unsigned T_ACCESS_NS = 70;
  localparam int unsigned CLK_NS      = 10;

  function automatic int unsigned min_cycles(input int unsigned ns, input int unsigned clk_ns);
    return (ns + clk_ns - 1) / clk_ns;
  endfunction

endpackage

// File: rtl/cellram_ctrl.sv
// Asynchronous-mode controller for a 16-bit cellular RAM (PSRAM).
// Turns a single-word req/ready handshake into timed CE#/OE#/WE#/LB#/UB# strobes.
// All pin-side outputs come straight from flops, so strobes are glitch-free.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   req, we, addr, wdata, be : request (sampled while ready=1)
//   ready                  : idle, next req edge is accepted
//   rdata, rvalid          : read data (held) and one-cycle completion pulse
//   ram_clk/adv_n/cre      : tied low (async mode)
//   ram_ce_n/oe_n/we_n/lb_n/ub_n : RAM strobes, active low
//   mem_adr, mem_db_o, mem_db_oe, mem_db_i : address, data pad out/enable/in
module cellram_ctrl
  import cellram_pkg::*;
#(
  parameter int unsigned ADDR_W         = 23,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned READ_CYCLES    = 8,
  parameter int unsigned WRITE_CYCLES   = 8,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned CLK_PERIOD_NS  = CLK_NS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        be,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              ram_clk,
  output logic              ram_adv_n,
  output logic              ram_cre,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              ram_lb_n,
  output logic              ram_ub_n,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_db_o,
  output logic              mem_db_oe,
  input  logic [DATA_W-1:0] mem_db_i
);

  // Elaboration-time guard against strobe widths shorter than the RAM access time.
  if (READ_CYCLES < min_cycles(T_ACCESS_NS, CLK_PERIOD_NS)) begin : g_rd_too_short
    $error("READ_CYCLES too small for the RAM access time");
  end
  if (WRITE_CYCLES < min_cycles(T_ACCESS_NS, CLK_PERIOD_NS)) begin : g_wr_too_short
    $error("WRITE_CYCLES too small for the RAM write cycle time");
  end
  if (RECOVER_CYCLES < 1) begin : g_rec_too_short
    $error("RECOVER_CYCLES must be at least 1");
  end

  localparam int unsigned MaxRw     = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int unsigned MaxCycles = (MaxRw > RECOVER_CYCLES) ? MaxRw : RECOVER_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] RdLast  = CntW'(READ_CYCLES - 1);
  localparam logic [CntW-1:0] WrLast  = CntW'(WRITE_CYCLES - 1);
  localparam logic [CntW-1:0] RecLast = CntW'(RECOVER_CYCLES - 1);

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                ready_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                ce_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   db_o_q;
  logic                db_oe_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      adr_q    <= '0;
      db_o_q   <= '0;
      db_oe_q  <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            adr_q   <= addr;
            db_o_q  <= wdata;
            lb_n_q  <= ~be[0];
            ub_n_q  <= ~be[1];
            ce_n_q  <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            if (we) begin
              state_q <= StWr;
              we_n_q  <= 1'b0;
              db_oe_q <= 1'b1;
            end else begin
              state_q <= StRd;
              oe_n_q  <= 1'b0;
            end
          end
        end
        StRd: begin
          if (cnt_q == RdLast) begin
            rdata_q  <= mem_db_i;
            rvalid_q <= 1'b1;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= StRecover;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWr: begin
          // Pad released on the same edge WE# rises: the RAM needs no data hold.
          if (cnt_q == WrLast) begin
            we_n_q  <= 1'b1;
            ce_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            db_oe_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= StRecover;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRecover: begin
          if (cnt_q == RecLast) begin
            ready_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign ram_clk   = 1'b0;
  assign ram_adv_n = 1'b0;
  assign ram_cre   = 1'b0;
  assign ram_ce_n  = ce_n_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;
  assign ram_lb_n  = lb_n_q;
  assign ram_ub_n  = ub_n_q;
  assign mem_adr   = adr_q;
  assign mem_db_o  = db_o_q;
  assign mem_db_oe = db_oe_q;

endmodule

// File: tb/tb_cellram_ctrl.sv
// Self-checking bench for cellram_ctrl: directed scenarios plus randomized traffic,
// a behavioural PSRAM pin model and a word-level reference memory.
module tb_cellram_ctrl;

  localparam int RD = 8;
  localparam int WR = 8;
  localparam int RC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [22:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  be = 2'b11;
  logic        ready, rvalid;
  logic [15:0] rdata;
  logic        ram_clk, ram_adv_n, ram_cre;
  logic        ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n;
  logic [22:0] mem_adr;
  logic [15:0] mem_db_o, mem_db_i;
  logic        mem_db_oe;

  cellram_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready), .rdata(rdata), .rvalid(rvalid),
    .ram_clk(ram_clk), .ram_adv_n(ram_adv_n), .ram_cre(ram_cre),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram_lb_n(ram_lb_n), .ram_ub_n(ram_ub_n),
    .mem_adr(mem_adr), .mem_db_o(mem_db_o), .mem_db_oe(mem_db_oe), .mem_db_i(mem_db_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Unwritten locations read back a fixed address-derived pattern.
  function automatic logic [15:0] init_val(input logic [22:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  // ---------------- PSRAM pin model ----------------
  logic [15:0] ram [int];
  always @(negedge clk) begin
    logic [15:0] w;
    w = ram.exists(int'(mem_adr)) ? ram[int'(mem_adr)] : init_val(mem_adr);
    if (!ram_ce_n && !ram_we_n && mem_db_oe) begin
      if (!ram_lb_n) w[7:0]  = mem_db_o[7:0];
      if (!ram_ub_n) w[15:8] = mem_db_o[15:8];
      ram[int'(mem_adr)] = w;
    end
    mem_db_i = (!ram_ce_n && !ram_oe_n) ? w : 16'h0000;
  end

  // ---------------- reference model ----------------
  logic [15:0] ref_mem [int];
  logic [15:0] exp_rd_q [$];
  int          acc_rd_q [$];
  logic        cur_we;
  logic [22:0] cur_addr;
  logic [15:0] cur_wdata;
  logic [1:0]  cur_be;
  int          last_acc = -100;
  int          gap;

  function automatic logic [15:0] ref_read(input logic [22:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  // Requests are presented right after a negedge; returns after the accept edge.
  task automatic do_req(input logic w, input logic [22:0] a, input logic [15:0] d,
                        input logic [1:0] b);
    int n = 0;
    logic [15:0] old;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    while (!ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("accept_timeout", 32'd1, 32'd0);
    cur_we = w; cur_addr = a; cur_wdata = d; cur_be = b;
    if (w) begin
      old = ref_read(a);
      ref_mem[int'(a)] = {b[1] ? d[15:8] : old[15:8], b[0] ? d[7:0] : old[7:0]};
    end else begin
      exp_rd_q.push_back(ref_read(a));
    end
    @(posedge clk);
    @(negedge clk);
    if (!w) acc_rd_q.push_back(cyc);
    gap = cyc - last_acc;
    last_acc = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- pin monitor ----------------
  int ce_cnt = 0, we_cnt = 0, oe_cnt = 0, bad = 0, rl = 0, overlap = 0, rv_cnt = 0;
  logic mon_we = 1'b0;
  always @(negedge clk) begin
    if (mem_db_oe && !ram_oe_n) overlap++;
    if (!rst_n) begin
      ce_cnt = 0; we_cnt = 0; oe_cnt = 0; bad = 0; rl = 0;
    end else begin
      if (!ram_ce_n) begin
        if (ce_cnt == 0) mon_we = cur_we;
        ce_cnt++;
        if (!ram_we_n) we_cnt++;
        if (!ram_oe_n) oe_cnt++;
        if (mem_adr !== cur_addr || {ram_ub_n, ram_lb_n} !== ~cur_be) bad++;
        if (cur_we && (mem_db_o !== cur_wdata || !mem_db_oe)) bad++;
        if (!cur_we && mem_db_oe) bad++;
      end else if (ce_cnt > 0) begin
        check("ce_len", ce_cnt, mon_we ? WR : RD);
        check("strobe_len", mon_we ? we_cnt : oe_cnt, mon_we ? WR : RD);
        check("wrong_strobe", mon_we ? oe_cnt : we_cnt, 0);
        check("pins_during_access", bad, 0);
        ce_cnt = 0; we_cnt = 0; oe_cnt = 0; bad = 0;
      end
      if (!ready) rl++;
      else if (rl > 0) begin
        check("ready_low_len", rl, mon_we ? WR + RC : RD + RC);
        rl = 0;
      end
      if (rvalid) begin
        rv_cnt++;
        if (exp_rd_q.size() == 0) check("rvalid_spurious", 32'd1, 32'd0);
        else begin
          check("rdata", rdata, exp_rd_q.pop_front());
          check("rd_latency", cyc - acc_rd_q.pop_front(), RD);
        end
      end
    end
  end

  int n_reads = 0;

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", ready, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n}, 5'b11111);
    check("rst_db", {mem_db_oe, mem_adr, mem_db_o}, 0);
    check("const_pins", {ram_clk, ram_adv_n, ram_cre}, 0);

    // Single write, read-back
    do_req(1'b1, 23'h000123, 16'hBEEF, 2'b11); req = 1'b0;
    wait_idle();
    do_req(1'b0, 23'h000123, 16'h0000, 2'b11); req = 1'b0; n_reads++;
    wait_idle();
    check("rd_beef", rdata, 16'hBEEF);

    // Byte write on the low lane only
    do_req(1'b1, 23'h000123, 16'h1234, 2'b01); req = 1'b0;
    wait_idle();
    do_req(1'b0, 23'h000123, 16'h0000, 2'b11); req = 1'b0; n_reads++;
    wait_idle();
    check("rd_be34", rdata, 16'hBE34);

    // No-op access with both lanes disabled
    do_req(1'b1, 23'h000123, 16'h5555, 2'b00); req = 1'b0;
    wait_idle();

    // Back-to-back reads with req held high
    do_req(1'b0, 23'h000000, 16'h0, 2'b11); n_reads++;
    for (int i = 1; i < 3; i++) begin
      do_req(1'b0, 23'(i), 16'h0, 2'b11); n_reads++;
      check("b2b_gap", gap, RD + RC + 1);
    end
    req = 1'b0;
    wait_idle();

    // Randomized traffic over a small address window
    for (int i = 0; i < 40; i++) begin
      logic w;
      w = 1'($urandom_range(0, 1));
      do_req(w, 23'($urandom_range(0, 15)), 16'($urandom), 2'($urandom));
      if (!w) n_reads++;
      if ($urandom_range(0, 2) != 0) begin
        req = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    req = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    // Reset during the fourth cycle of a write
    do_req(1'b1, 23'h7FFFFF, 16'hCAFE, 2'b11); req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_strobes", {ram_we_n, ram_ce_n, mem_db_oe}, 3'b110);
    check("abort_rvalid", rvalid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", ready, 1);
    repeat (12) @(negedge clk);

    check("rvalid_count", rv_cnt, n_reads);
    check("rd_queue_empty", exp_rd_q.size(), 0);
    check("oe_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
